// File: rtl/nios_system_led_pio_ex.sv
// Avalon-MM output PIO for LED banks: DATA register with atomic
// set/clear/toggle strobes, per-bit blink mask and a programmable
// blink prescaler. Zero-wait-state slave, combinational read data.
`timescale 1ns/1ps
module nios_system_led_pio_ex #(
    parameter int unsigned WIDTH       = 8,
    parameter logic [31:0] RESET_VALUE = 32'd0,
    parameter int unsigned DIV_W       = 24,
    parameter logic [31:0] DIV_RESET   = 32'd0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_SET    = 3'd1;
    localparam logic [2:0] ADDR_CLEAR  = 3'd2;
    localparam logic [2:0] ADDR_TOGGLE = 3'd3;
    localparam logic [2:0] ADDR_EN     = 3'd4;
    localparam logic [2:0] ADDR_DIV    = 3'd5;
    localparam logic [2:0] ADDR_STATUS = 3'd6;

    // STATUS has 31 bits for the counter above the phase bit
    localparam int unsigned STAT_CNT_W = (DIV_W < 32) ? DIV_W : 31;

    logic             wr;
    logic [WIDTH-1:0] wd_data;
    logic [DIV_W-1:0] wd_div;
    logic             unused_wd;

    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] blink_en_q, blink_en_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;

    assign wr        = chipselect & ~write_n;
    assign wd_data   = writedata[WIDTH-1:0];
    assign wd_div    = writedata[DIV_W-1:0];
    assign unused_wd = ^writedata;

    // Next value of the data and blink mask registers from bus writes
    always_comb begin
        data_d     = data_q;
        blink_en_d = blink_en_q;
        if (wr) begin
            case (address)
                ADDR_DATA:   data_d     = wd_data;
                ADDR_SET:    data_d     = data_q | wd_data;
                ADDR_CLEAR:  data_d     = data_q & ~wd_data;
                ADDR_TOGGLE: data_d     = data_q ^ wd_data;
                ADDR_EN:     blink_en_d = wd_data;
                default:     ;
            endcase
        end
    end

    // Blink prescaler: a reload write wins, zero divider stops the blink
    always_comb begin
        div_d   = div_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (wr && (address == ADDR_DIV)) begin
            div_d   = wd_div;
            cnt_d   = wd_div;
            phase_d = 1'b0;
        end else if (div_q == '0) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (cnt_q == '0) begin
            cnt_d   = div_q;
            phase_d = ~phase_q;
        end else begin
            cnt_d   = cnt_q - DIV_W'(1);
        end
    end

    // Register state with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q     <= RESET_VALUE[WIDTH-1:0];
            blink_en_q <= '0;
            div_q      <= DIV_RESET[DIV_W-1:0];
            cnt_q      <= DIV_RESET[DIV_W-1:0];
            phase_q    <= 1'b0;
        end else begin
            data_q     <= data_d;
            blink_en_q <= blink_en_d;
            div_q      <= div_d;
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
        end
    end

    // Zero-extended read mux; chipselect is deliberately ignored
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:   readdata[WIDTH-1:0] = data_q;
            ADDR_EN:     readdata[WIDTH-1:0] = blink_en_q;
            ADDR_DIV:    readdata[DIV_W-1:0] = div_q;
            ADDR_STATUS: begin
                readdata[0]            = phase_q;
                readdata[STAT_CNT_W:1] = cnt_q[STAT_CNT_W-1:0];
            end
            default:     ;
        endcase
    end

    // Blinking bits go dark during phase 1
    always_comb begin
        out_port = data_q & ~(blink_en_q & {WIDTH{phase_q}});
    end

endmodule

// File: tb/tb_nios_system_led_pio_ex.sv
// Self-checking bench for nios_system_led_pio_ex. Two instances with
// different widths/resets share one bus and are checked against an
// abstract model that derives cnt/phase from elapsed cycles since load.
`timescale 1ns/1ps
module tb_nios_system_led_pio_ex;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata_a, readdata_b;
    logic [7:0]  out_a;
    logic [15:0] out_b;

    int total = 0;
    int bad   = 0;

    nios_system_led_pio_ex #(
        .WIDTH(8), .RESET_VALUE(32'hA5), .DIV_W(8), .DIV_RESET(32'd0)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .address(address),
        .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
        .readdata(readdata_a), .out_port(out_a)
    );

    nios_system_led_pio_ex #(
        .WIDTH(16), .RESET_VALUE(32'h1234), .DIV_W(24), .DIV_RESET(32'd2)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .address(address),
        .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
        .readdata(readdata_b), .out_port(out_b)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // ---------------- reference model ----------------
    logic [31:0] WM[2] = '{32'h0000_00FF, 32'h0000_FFFF};
    logic [31:0] DM[2] = '{32'h0000_00FF, 32'h00FF_FFFF};
    logic [31:0] RV[2] = '{32'h0000_00A5, 32'h0000_1234};
    logic [31:0] DR[2] = '{32'd0, 32'd2};

    logic [31:0] m_data[2];
    logic [31:0] m_en[2];
    logic [31:0] m_div[2];
    int          m_t[2];   // clock edges since the counter was last loaded

    function automatic logic m_phase(int i);
        if (m_div[i] == 0) return 1'b0;
        return ((m_t[i] / (int'(m_div[i]) + 1)) % 2) == 1;
    endfunction

    function automatic logic [31:0] m_cnt(int i);
        if (m_div[i] == 0) return 32'd0;
        return m_div[i] - 32'(m_t[i] % (int'(m_div[i]) + 1));
    endfunction

    function automatic logic [31:0] m_out(int i);
        return m_data[i] & ~(m_en[i] & (m_phase(i) ? WM[i] : 32'd0));
    endfunction

    function automatic logic [31:0] m_rd(int i, logic [2:0] a);
        logic [31:0] c;
        c = m_cnt(i);
        case (a)
            3'd0:    return m_data[i];
            3'd4:    return m_en[i];
            3'd5:    return m_div[i];
            3'd6:    return {c[30:0], m_phase(i)};
            default: return 32'd0;
        endcase
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 2; i++) begin
            m_data[i] = RV[i];
            m_en[i]   = 32'd0;
            m_div[i]  = DR[i];
            m_t[i]    = 0;
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic cs, input logic wn, input logic [2:0] a, input logic [31:0] wd);
        chipselect = cs;
        write_n    = wn;
        address    = a;
        writedata  = wd;
        @(posedge clk);
        if (reset_n) begin
            for (int i = 0; i < 2; i++) begin
                if (cs && !wn) begin
                    case (a)
                        3'd0: m_data[i] = wd & WM[i];
                        3'd1: m_data[i] = m_data[i] | (wd & WM[i]);
                        3'd2: m_data[i] = m_data[i] & ~(wd & WM[i]);
                        3'd3: m_data[i] = m_data[i] ^ (wd & WM[i]);
                        3'd4: m_en[i]   = wd & WM[i];
                        default: ;
                    endcase
                end
                if (cs && !wn && a == 3'd5) begin
                    m_div[i] = wd & DM[i];
                    m_t[i]   = 0;
                end else begin
                    m_t[i]++;
                end
            end
        end
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [31:0] wd);
        step(1'b1, 1'b0, a, wd);
    endtask

    task automatic idle();
        step(1'b0, 1'b1, 3'd0, 32'd0);
    endtask

    task automatic rd(input logic [2:0] a);
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = a;
        #1;
    endtask

    // Compare outputs and every register of both instances with the model
    task automatic chk_all();
        chk("out_a", 32'(out_a), m_out(0));
        chk("out_b", 32'(out_b), m_out(1));
        for (int a = 0; a < 8; a++) begin
            rd(3'(a));
            chk($sformatf("rd_a[%0d]", a), readdata_a, m_rd(0, 3'(a)));
            chk($sformatf("rd_b[%0d]", a), readdata_b, m_rd(1, 3'(a)));
        end
    endtask

    typedef struct {
        logic [2:0]  addr;
        logic [31:0] wd;
        logic [31:0] exp_a;
    } vec_t;

    vec_t tbl[4];

    initial begin
        tbl[0] = '{3'd0, 32'h0000_000F, 32'h0F};
        tbl[1] = '{3'd1, 32'h0000_00F0, 32'hFF};
        tbl[2] = '{3'd2, 32'h0000_0081, 32'h7E};
        tbl[3] = '{3'd3, 32'h0000_0003, 32'h7D};

        reset_n    = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 3'd0;
        writedata  = 32'd0;
        m_reset();

        // reset state
        @(posedge clk);
        #1;
        chk("rst_out_a", 32'(out_a), 32'hA5);
        rd(3'd0);
        chk("rst_data_a", readdata_a, 32'h0000_00A5);
        rd(3'd6);
        chk("rst_status_a", readdata_a, 32'd0);
        chk("rst_status_b", readdata_b, 32'h4);
        reset_n = 1'b1;
        chk_all();

        // data register and atomic strobes
        foreach (tbl[k]) begin
            wr_reg(tbl[k].addr, tbl[k].wd);
            chk($sformatf("tbl_out_a[%0d]", k), 32'(out_a), tbl[k].exp_a);
            rd(3'd0);
            chk($sformatf("tbl_data_a[%0d]", k), readdata_a, tbl[k].exp_a);
            chk_all();
        end
        for (int a = 1; a < 8; a++) begin
            if (a == 4 || a == 5 || a == 6) continue;
            rd(3'(a));
            chk($sformatf("wo_zero_a[%0d]", a), readdata_a, 32'd0);
        end

        // blink with div=3: 4 cycles lit, 4 cycles dimmed
        wr_reg(3'd0, 32'hFF);
        wr_reg(3'd4, 32'h0F);
        wr_reg(3'd5, 32'd3);
        for (int k = 0; k < 16; k++) begin
            chk("blink_out_a", 32'(out_a), ((k / 4) % 2 == 1) ? 32'hF0 : 32'hFF);
            rd(3'd6);
            chk("blink_status_a", readdata_a,
                (32'(3 - (k % 4)) << 1) | 32'((k / 4) % 2));
            chk_all();
            idle();
        end

        // stop blinking while in phase 1
        repeat (5) idle();
        chk("ph1_out_a", 32'(out_a), 32'hF0);
        wr_reg(3'd5, 32'd0);
        for (int k = 0; k < 3; k++) begin
            chk("stop_out_a", 32'(out_a), 32'hFF);
            rd(3'd6);
            chk("stop_status_a", readdata_a, 32'd0);
            chk_all();
            idle();
        end

        // deselected write is ignored, upper bits discarded
        step(1'b0, 1'b0, 3'd0, 32'h0000_0055);
        rd(3'd0);
        chk("desel_data_a", readdata_a, 32'hFF);
        wr_reg(3'd0, 32'hFFFF_FF00);
        rd(3'd0);
        chk("trunc_data_a", readdata_a, 32'h0);
        chk("trunc_data_b", readdata_b, 32'h0000_FF00);
        chk_all();

        // reset asserted mid-blink in phase 1
        wr_reg(3'd0, 32'hFF);
        wr_reg(3'd5, 32'd1);
        idle();
        idle();
        chk("pre_rst_out_a", 32'(out_a), 32'hF0);
        #3;
        reset_n = 1'b0;
        #1;
        chk("async_rst_out_a", 32'(out_a), 32'hA5);
        chk("async_rst_out_b", 32'(out_b), 32'h1234);
        m_reset();
        idle();
        idle();
        reset_n = 1'b1;
        rd(3'd6);
        chk("post_rst_status_b", readdata_b, 32'h4);
        for (int k = 1; k < 10; k++) begin
            idle();
            rd(3'd6);
            chk("rst_phase_b", 32'(readdata_b[0]), 32'((k / 3) % 2));
            chk("rst_cnt_b", readdata_b >> 1, 32'(2 - (k % 3)));
            chk_all();
        end

        // randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            logic [2:0]  a;
            logic [31:0] wd;
            a  = 3'($urandom_range(0, 7));
            wd = $urandom;
            if (a == 3'd5)
                wd = $urandom_range(0, 6) | (($urandom_range(0, 1) == 1) ? 32'hFF00_0000 : 32'd0);
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0), a, wd);
            chk("rnd_out_a", 32'(out_a), m_out(0));
            chk("rnd_out_b", 32'(out_b), m_out(1));
            a = 3'($urandom_range(0, 7));
            rd(a);
            chk("rnd_rd_a", readdata_a, m_rd(0, a));
            chk("rnd_rd_b", readdata_b, m_rd(1, a));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nios_system_led_pio_ex.md
Name: nios_system_led_pio_ex

Overview:
Parametrised Avalon-MM output PIO for LED banks. It is the successor to the fixed 8-bit LED port in the Nios system. It adds atomic set/clear/toggle write registers and a per-bit hardware blink engine driven by a programmable prescaler. It sits on the system interconnect as a zero-wait-state slave and drives board LEDs directly.

Parameters:
WIDTH, 8, output port width in bits; legal range 1..32.
RESET_VALUE, 0, value of DATA after reset; only the low WIDTH bits are used.
DIV_W, 24, width of the blink prescaler; legal range 1..32.
DIV_RESET, 0, value of BLINK_DIV after reset; 0 means blink stopped.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
address  in  3  word address of the register
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  32  write data
readdata  out  32  read data; combinational, read latency 0
out_port  out  WIDTH  LED drive

Behaviour:
- One clock domain (clk). Reset is asynchronous and active-low on reset_n; it is asserted asynchronously and all flops clear at once.
- Write strobe: wr = chipselect & ~write_n. No wait states. Only writedata[WIDTH-1:0] is used, except BLINK_DIV, which uses [DIV_W-1:0].
- Register map (word addresses):
  - 0 DATA: read/write. A write replaces data.
  - 1 SET: write-only. data <= data | wd. Reads return 0.
  - 2 CLEAR: write-only. data <= data & ~wd. Reads return 0.
  - 3 TOGGLE: write-only. data <= data ^ wd. Reads return 0.
  - 4 BLINK_EN: read/write per-bit blink mask.
  - 5 BLINK_DIV: read/write prescaler reload value.
  - 6 STATUS: read-only. Bit 0 = phase, bits [DIV_W+0:1] = current cnt, truncated to 31 bits if DIV_W = 32. Writes are ignored.
  - 7: reserved. Reads return 0; writes are ignored.
- readdata = zero-extended mux of the addressed register. It is combinational from address and flops and ignores chipselect. Unused upper bits are 0.
- Reset values:
  - data = RESET_VALUE[WIDTH-1:0]
  - blink_en = 0
  - div = DIV_RESET
  - cnt = DIV_RESET
  - phase = 0
  - out_port = RESET_VALUE[WIDTH-1:0]
- Prescaler, evaluated every clk in this priority order:
  1. Write to BLINK_DIV: div <= wd, cnt <= wd, phase <= 0.
  2. Else if div == 0: cnt <= 0, phase <= 0 (blink stopped).
  3. Else if cnt == 0: cnt <= div, phase <= ~phase.
  4. Else: cnt <= cnt - 1.
  - With a nonzero div, phase toggles every div+1 cycles. The blink period is 2*(div+1) cycles.
- Output:
  - out_port = data & ~(blink_en & {WIDTH{phase}}).
  - It is combinational from flops, so a register write becomes visible on out_port the cycle after the write edge.
  - A blinking bit with data = 1 is lit during phase 0 and dark during phase 1. A bit with data = 0 stays dark regardless of blink_en.
- Writes to BLINK_EN do not disturb cnt or phase.
- Reset asserted mid-blink returns everything to reset values immediately. After release, counting restarts from DIV_RESET.
- Only one access per cycle can occur; there are no simultaneous register writes to resolve.

Test Plan:
1. Reset with RESET_VALUE=8'hA5 -> out_port=8'hA5, readdata at address 0 = 32'h000000A5, STATUS=0.
2. Write DATA=8'h0F, then SET 8'hF0, CLEAR 8'h81, TOGGLE 8'h03 -> DATA reads 8'h0F, 8'hFF, 8'h7E, 8'h7D in turn. out_port tracks each value one cycle after the write. Reads of addresses 1, 2, 3 and 7 return 0.
3. Write DATA=8'hFF, BLINK_EN=8'h0F, BLINK_DIV=3 -> out_port alternates 8'hFF for 4 cycles, then 8'hF0 for 4 cycles, repeating. STATUS cnt sequence is 3,2,1,0.
4. While blinking, write BLINK_DIV=0 -> phase forced to 0 on the next cycle, out_port=8'hFF held steady, STATUS reads 0.
5. Write with chipselect=0, and writedata=32'hFFFFFF00 to DATA -> no change from the deselected write. DATA becomes 8'h00 and the upper bits read back as 0.
6. Assert reset_n mid-blink with phase=1 -> out_port returns to RESET_VALUE asynchronously, without waiting for a clk edge. After release, phase resumes toggling every DIV_RESET+1 cycles; with DIV_W=24 and WIDTH=16 the same checks pass.
